// File: rtl/tank_ctrl_param.sv
// tank_ctrl_param: per-player tank motion/fire controller, updated once per video frame
// Ports: i_frame_clk/i_reset_n (sync, active-low); i_hit, i_game_end, i_wall_hit event inputs;
//   i_sin/i_cos sign-magnitude heading vector; i_keycode KEY_SLOTS x 8-bit report; i_spawn_pos tile spawn;
//   o_tank_x/o_tank_y/o_tank_size/o_step_x/o_step_y/o_angle/o_fire/o_alive/o_state registered outputs.
// Optional: define FIRE_EDGE_EN to require FIRE release between shots (default: auto-repeat).
module tank_ctrl_param #(
  parameter int KEY_SLOTS = 4,
  parameter int POS_W = 10,
  parameter int ANGLE_STEPS = 45,
  parameter int STEP_MAG = 12,
  parameter int FIRE_COOLDOWN = 16,
  parameter int RESPAWN_DELAY = 60,
  parameter int X_CENTER = 300,
  parameter int Y_CENTER = 250,
  parameter logic [7:0] KEY_UP = 8'h52,
  parameter logic [7:0] KEY_DOWN = 8'h51,
  parameter logic [7:0] KEY_CW = 8'h50,
  parameter logic [7:0] KEY_CCW = 8'h4F,
  parameter logic [7:0] KEY_FIRE = 8'h2C
) (
  input  logic                   i_frame_clk,
  input  logic                   i_reset_n,
  input  logic                   i_hit,
  input  logic [1:0]             i_game_end,
  input  logic [3:0]             i_wall_hit,
  input  logic [7:0]             i_sin,
  input  logic [7:0]             i_cos,
  input  logic [8*KEY_SLOTS-1:0] i_keycode,
  input  logic [9:0]             i_spawn_pos,
  output logic [POS_W-1:0]       o_tank_x,
  output logic [POS_W-1:0]       o_tank_y,
  output logic [POS_W-1:0]       o_tank_size,
  output logic [POS_W-1:0]       o_step_x,
  output logic [POS_W-1:0]       o_step_y,
  output logic [5:0]             o_angle,
  output logic                   o_fire,
  output logic                   o_alive,
  output logic [1:0]             o_state
);
  localparam int CD_W = $clog2(FIRE_COOLDOWN + 1);
  localparam int DD_W = $clog2(RESPAWN_DELAY + 1);
  localparam logic [POS_W-1:0] XC = POS_W'(X_CENTER);
  localparam logic [POS_W-1:0] YC = POS_W'(Y_CENTER);
  localparam logic [5:0] A_MAX = 6'(ANGLE_STEPS - 1);
  localparam logic [CD_W-1:0] CD_INIT = CD_W'(FIRE_COOLDOWN - 1);
  localparam logic [DD_W-1:0] DD_INIT = DD_W'(RESPAWN_DELAY - 1);
  localparam logic [6:0] MAG = 7'(STEP_MAG);
  typedef enum logic [1:0] {ALIVE = 2'd0, DEAD = 2'd1, FROZEN = 2'd2} state_t;
  state_t r_state, w_state;
  logic [POS_W-1:0] r_x, r_y, r_px, r_py, r_sx, r_sy;
  logic [POS_W-1:0] w_x, w_y, w_px, w_py, w_sx, w_sy;
  logic [POS_W-1:0] w_mx, w_my, w_dx, w_dy;
  logic [13:0] w_prod_x, w_prod_y;
  logic [5:0] r_angle, w_angle;
  logic [CD_W-1:0] r_cd, w_cd;
  logic [DD_W-1:0] r_dead, w_dead;
  logic r_fire, w_fire, w_shoot, w_fire_ok;
  logic w_up, w_down, w_cw, w_ccw, w_fire_key;
  always_comb begin
    w_up = 1'b0;
    w_down = 1'b0;
    w_cw = 1'b0;
    w_ccw = 1'b0;
    w_fire_key = 1'b0;
    for (int s = 0; s < KEY_SLOTS; s++) begin
      w_up = w_up | (i_keycode[8*s +: 8] == KEY_UP);
      w_down = w_down | (i_keycode[8*s +: 8] == KEY_DOWN);
      w_cw = w_cw | (i_keycode[8*s +: 8] == KEY_CW);
      w_ccw = w_ccw | (i_keycode[8*s +: 8] == KEY_CCW);
      w_fire_key = w_fire_key | (i_keycode[8*s +: 8] == KEY_FIRE);
    end
  end
  // Speed scaled by the Q0.7 magnitudes; screen Y grows downward, so a positive sin moves up.
  assign w_prod_x = {7'd0, MAG} * {7'd0, i_cos[6:0]};
  assign w_prod_y = {7'd0, MAG} * {7'd0, i_sin[6:0]};
  assign w_mx = POS_W'(w_prod_x >> 7);
  assign w_my = POS_W'(w_prod_y >> 7);
  assign w_dx = i_cos[7] ? -w_mx : w_mx;
  assign w_dy = i_sin[7] ? w_my : -w_my;
`ifdef FIRE_EDGE_EN
  logic r_fire_seen;
  assign w_fire_ok = w_fire_key && !r_fire_seen;
  always_ff @(posedge i_frame_clk)
    if (!i_reset_n) r_fire_seen <= 1'b0;
    else r_fire_seen <= w_fire_key && (r_fire_seen || w_shoot);
`else
  assign w_fire_ok = w_fire_key;
`endif
  always_comb begin
    w_state = r_state;
    w_x = r_x;
    w_y = r_y;
    w_px = r_px;
    w_py = r_py;
    w_sx = '0;
    w_sy = '0;
    w_angle = r_angle;
    w_cd = (r_cd != '0) ? r_cd - CD_W'(1) : r_cd;
    w_dead = r_dead;
    w_shoot = 1'b0;
    if (i_game_end != 2'b00) begin
      w_state = FROZEN;
      w_x = POS_W'({i_spawn_pos[4:0], 5'b0});
      w_y = POS_W'({i_spawn_pos[9:5], 5'b0});
      w_angle = '0;
      w_cd = '0;
      w_dead = '0;
    end else if (r_state == FROZEN) begin
      w_state = ALIVE;
    end else if (r_state == DEAD) begin
      if (r_dead == '0) begin
        w_state = ALIVE;
        w_x = XC;
        w_y = YC;
        w_angle = '0;
        w_cd = '0;
      end else begin
        w_dead = r_dead - DD_W'(1);
      end
    end else if (i_hit) begin
      w_state = DEAD;
      w_dead = DD_INIT;
    end else begin
      w_shoot = w_fire_ok && (r_cd == '0);
      if (w_shoot) w_cd = CD_INIT;
      // A wall contact undoes the last move and suppresses this frame's motion and rotation.
      if (|i_wall_hit) begin
        w_x = r_px;
        w_y = r_py;
      end else if (w_up || w_down) begin
        w_px = r_x;
        w_py = r_y;
        w_sx = w_up ? w_dx : -w_dx;
        w_sy = w_up ? w_dy : -w_dy;
        w_x = r_x + w_sx;
        w_y = r_y + w_sy;
      end else if (w_cw) begin
        w_angle = (r_angle == A_MAX) ? 6'd0 : r_angle + 6'd1;
      end else if (w_ccw) begin
        w_angle = (r_angle == 6'd0) ? A_MAX : r_angle - 6'd1;
      end
    end
    w_fire = w_shoot;
  end
  always_ff @(posedge i_frame_clk) begin
    if (!i_reset_n) begin
      r_state <= ALIVE;
      r_x <= XC;
      r_y <= YC;
      r_px <= XC;
      r_py <= YC;
      r_sx <= '0;
      r_sy <= '0;
      r_angle <= '0;
      r_fire <= 1'b0;
      r_cd <= '0;
      r_dead <= '0;
    end else begin
      r_state <= w_state;
      r_x <= w_x;
      r_y <= w_y;
      r_px <= w_px;
      r_py <= w_py;
      r_sx <= w_sx;
      r_sy <= w_sy;
      r_angle <= w_angle;
      r_fire <= w_fire;
      r_cd <= w_cd;
      r_dead <= w_dead;
    end
  end
  assign o_tank_x = r_x;
  assign o_tank_y = r_y;
  assign o_tank_size = POS_W'(10);
  assign o_step_x = r_sx;
  assign o_step_y = r_sy;
  assign o_angle = r_angle;
  assign o_fire = r_fire;
  assign o_alive = (r_state != DEAD);
  assign o_state = r_state;
endmodule

// File: tb/tb_tank_ctrl_param.sv
// tb_tank_ctrl_param: random + directed bench for tank_ctrl_param against a frame-level reference model
module tb_tank_ctrl_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hit = 1'b0;
  logic [1:0] game_end = 2'b00;
  logic [3:0] wall_hit = 4'b0000;
  logic [7:0] sin_i = 8'h00;
  logic [7:0] cos_i = 8'h00;
  logic [31:0] keycode = 32'h0;
  logic [9:0] spawn_pos = 10'h0;
  logic [9:0] tank_x, tank_y, tank_size, step_x, step_y;
  logic [5:0] angle;
  logic fire, alive;
  logic [1:0] state;
  int checks = 0;
  int failures = 0;
  bit run = 1'b0;
  int m_x, m_y, m_px, m_py, m_sx, m_sy, m_ang, m_fire, m_cd, m_dead, m_state, m_seen;
  tank_ctrl_param dut (
    .i_frame_clk(clk), .i_reset_n(rst_n), .i_hit(hit), .i_game_end(game_end),
    .i_wall_hit(wall_hit), .i_sin(sin_i), .i_cos(cos_i), .i_keycode(keycode),
    .i_spawn_pos(spawn_pos), .o_tank_x(tank_x), .o_tank_y(tank_y), .o_tank_size(tank_size),
    .o_step_x(step_x), .o_step_y(step_y), .o_angle(angle), .o_fire(fire),
    .o_alive(alive), .o_state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask
  // Frame-level reference: what one frame does to the tank, straight from the game rules.
  task automatic model_step();
    bit up, dn, cw, ccw, fk;
    int mx, my, dx, dy, ncd, nfire, nsx, nsy;
    logic [7:0] k;
    up = 0; dn = 0; cw = 0; ccw = 0; fk = 0;
    for (int s = 0; s < 4; s++) begin
      k = keycode[8*s +: 8];
      up |= (k == 8'h52); dn |= (k == 8'h51); cw |= (k == 8'h50);
      ccw |= (k == 8'h4F); fk |= (k == 8'h2C);
    end
    mx = (12 * int'(cos_i[6:0])) / 128;
    my = (12 * int'(sin_i[6:0])) / 128;
    dx = cos_i[7] ? -mx : mx;
    dy = sin_i[7] ? my : -my;
    if (!rst_n) begin
      m_x = 300; m_y = 250; m_px = 300; m_py = 250; m_sx = 0; m_sy = 0;
      m_ang = 0; m_fire = 0; m_cd = 0; m_dead = 0; m_state = 0; m_seen = 0;
    end else begin
      ncd = (m_cd > 0) ? m_cd - 1 : 0;
      nfire = 0; nsx = 0; nsy = 0;
      if (game_end != 0) begin
        m_state = 2; m_x = int'(spawn_pos[4:0]) * 32; m_y = int'(spawn_pos[9:5]) * 32;
        m_ang = 0; ncd = 0; m_dead = 0;
      end else if (m_state == 2) begin
        m_state = 0;
      end else if (m_state == 1) begin
        if (m_dead == 0) begin
          m_state = 0; m_x = 300; m_y = 250; m_ang = 0; ncd = 0;
        end else m_dead--;
      end else if (hit) begin
        m_state = 1; m_dead = 59;
      end else begin
`ifdef FIRE_EDGE_EN
        if (fk && m_cd == 0 && !m_seen) begin nfire = 1; ncd = 15; end
`else
        if (fk && m_cd == 0) begin nfire = 1; ncd = 15; end
`endif
        if (wall_hit != 0) begin
          m_x = m_px; m_y = m_py;
        end else if (up || dn) begin
          m_px = m_x; m_py = m_y;
          nsx = up ? dx : -dx; nsy = up ? dy : -dy;
          m_x = (m_x + nsx) & 1023; m_y = (m_y + nsy) & 1023;
        end else if (cw) m_ang = (m_ang + 1) % 45;
        else if (ccw) m_ang = (m_ang + 44) % 45;
      end
      m_cd = ncd; m_fire = nfire; m_sx = nsx & 1023; m_sy = nsy & 1023;
      m_seen = (fk && (m_seen || nfire)) ? 1 : 0;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask
  always @(negedge clk) if (run) begin
    chk("x", int'(tank_x), m_x);
    chk("y", int'(tank_y), m_y);
    chk("step_x", int'(step_x), m_sx);
    chk("step_y", int'(step_y), m_sy);
    chk("angle", int'(angle), m_ang);
    chk("fire", int'(fire), m_fire);
    chk("state", int'(state), m_state);
    chk("alive", int'(alive), (m_state != 1) ? 1 : 0);
    chk("size", int'(tank_size), 10);
  end
  function automatic logic [7:0] rand_key();
    int r;
    r = $urandom_range(0, 9);
    return (r == 0) ? 8'h52 : (r == 1) ? 8'h51 : (r == 2) ? 8'h50 : (r == 3) ? 8'h4F :
           (r == 4) ? 8'h2C : (r < 8) ? 8'h00 : 8'($urandom);
  endfunction
  initial begin
    int pulses, first, second, n, ge_hold, fired_dead;
    tick();
    run = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("rst_x", int'(tank_x), 300);
    chk("rst_y", int'(tank_y), 250);
    chk("rst_angle", int'(angle), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_fire", int'(fire), 0);
    cos_i = 8'h7F; sin_i = 8'h00; keycode = 32'h0052_0000;
    tick();
    chk("up_x", int'(tank_x), 311);
    chk("up_y", int'(tank_y), 250);
    chk("up_step_x", int'(step_x), 11);
    keycode = 32'h0; wall_hit = 4'b0010;
    tick();
    chk("wall_x", int'(tank_x), 300);
    chk("wall_step", int'(step_x), 0);
    wall_hit = 4'b0000; keycode = 32'h0000_004F;
    tick();
    chk("ccw_wrap", int'(angle), 44);
    keycode = 32'h0000_0050;
    tick();
    tick();
    chk("cw_twice", int'(angle), 1);
    rst_n = 1'b0; keycode = 32'h2C00_0000;
    tick();
    rst_n = 1'b1;
    pulses = 0; first = -1; second = -1;
    for (int f = 1; f <= 40; f++) begin
      tick();
      if (fire) begin
        pulses++;
        if (first < 0) first = f; else if (second < 0) second = f;
      end
    end
`ifdef FIRE_EDGE_EN
    chk("fire_pulses", pulses, 1);
`else
    chk("fire_pulses", pulses, 3);
    chk("fire_second", second, 17);
`endif
    chk("fire_first", first, 1);
    keycode = 32'h0000_0050;
    tick();
    keycode = 32'h0000_0052;
    tick();
    chk("pre_hit_x", int'(tank_x), 311);
    hit = 1'b1; keycode = 32'h0000_2C52;
    tick();
    chk("hit_state", int'(state), 1);
    chk("hit_alive", int'(alive), 0);
    chk("hit_hold_x", int'(tank_x), 311);
    n = 0; fired_dead = 0;
    for (int i = 1; i <= 100; i++) begin
      hit = (i == 10);
      tick();
      if (state == 1 && fire) fired_dead++;
      if (state != 1) begin n = i; break; end
    end
    hit = 1'b0; keycode = 32'h0;
    chk("dead_frames", n, 60);
    chk("dead_fire", fired_dead, 0);
    chk("respawn_x", int'(tank_x), 300);
    chk("respawn_y", int'(tank_y), 250);
    chk("respawn_angle", int'(angle), 0);
    game_end = 2'b01; spawn_pos = 10'b00011_00101;
    tick();
    keycode = 32'h0000_0052;
    tick();
    chk("freeze_x", int'(tank_x), 160);
    chk("freeze_y", int'(tank_y), 96);
    chk("freeze_state", int'(state), 2);
    game_end = 2'b00; keycode = 32'h0;
    tick();
    chk("thaw_state", int'(state), 0);
    chk("thaw_x", int'(tank_x), 160);
    chk("thaw_y", int'(tank_y), 96);
    ge_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if (ge_hold > 0) ge_hold--;
      else if ($urandom_range(0, 39) == 0) ge_hold = $urandom_range(1, 5);
      game_end = (ge_hold > 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      hit = ($urandom_range(0, 24) == 0);
      wall_hit = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      sin_i = 8'($urandom);
      cos_i = 8'($urandom);
      spawn_pos = 10'($urandom);
      for (int s = 0; s < 4; s++) keycode[8*s +: 8] = rand_key();
      tick();
    end
    @(posedge clk);
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tank_ctrl_param.md
Name: tank_ctrl_param

Overview:
Parametrised, next-generation tank motion/fire controller, one instance per player, clocked once per video frame. Decodes a multi-slot keyboard report with per-instance keymaps. Produces tank position, heading angle and a rate-limited fire pulse. Adds respawn delay, game-end freeze, wall rollback to the previous position, and fire cooldown. Feeds the sprite renderer, bullet spawner and wall-collision logic.

Parameters:
KEY_SLOTS, 4, number of 8-bit keycode slots scanned
POS_W, 10, position/step width
ANGLE_STEPS, 45, heading positions (2..64); angle wraps modulo this
STEP_MAG, 12, speed magnitude 0..127 (scaled by sin/cos)
FIRE_COOLDOWN, 16, frames between shots
RESPAWN_DELAY, 60, frames spent dead after a hit
X_CENTER, 300, respawn/reset X
Y_CENTER, 250, respawn/reset Y
KEY_UP/KEY_DOWN/KEY_CW/KEY_CCW/KEY_FIRE, 8'h52/8'h51/8'h50/8'h4F/8'h2C, keymap

Ports:
frame_clk  in  1  frame clock
Reset  in  1  active-low, synchronous to frame_clk
hit  in  1  tank struck this frame
game_end  in  2  nonzero = round over
wall_hit  in  4  {bottom,top,right,left} collision flags
sin, cos  in  8  sign-magnitude (bit7 sign, [6:0] Q0.7 magnitude) of current angle
keycode  in  8*KEY_SLOTS  key report; slot i = [8i+7:8i]
spawn_pos  in  10  {y_tile[9:5], x_tile[4:0]}, tiles of 32 px
tank_x, tank_y  out  POS_W  position
tank_size  out  POS_W  constant 10
step_x, step_y  out  POS_W  two's-complement motion applied this frame
angle  out  6  heading index 0..ANGLE_STEPS-1
fire  out  1  one-frame shot pulse
alive  out  1  1 in ALIVE/FROZEN
state  out  2  ALIVE=0, DEAD=1, FROZEN=2

Behaviour:
- All registers update on the rising edge of frame_clk. Outputs are registered: one frame of latency from inputs.
- Reset low: tank_x=X_CENTER, tank_y=Y_CENTER, step=0, angle=0, fire=0, cooldown=0, dead counter=0, alive=1, state=ALIVE, prev_x/prev_y=center.
- Event priority: Reset > game_end!=0 > hit > wall_hit > keys.
- Key decode: a key is pressed if any slot equals its code. Motion priority: UP > DOWN > CW > CCW. FIRE is independent of motion.
- Motion: mx=(STEP_MAG*cos[6:0])>>7 and my=(STEP_MAG*sin[6:0])>>7, zero-extended to POS_W.
  - dx = cos[7] ? -mx : mx; dy = sin[7] ? my : -my (screen Y grows downward).
  - UP applies (+dx,+dy); DOWN applies (-dx,-dy).
  - Position adds modulo 2^POS_W. step_x/step_y = applied delta, else 0.
- Before every applied move, prev_x/prev_y latch the current position.
- Wall: if any wall_hit bit is set in ALIVE: position <- prev, step=0, no move/rotate that frame, fire still evaluated.
- Angle: CW +1, with ANGLE_STEPS-1 -> 0. CCW -1, with 0 -> ANGLE_STEPS-1. Never outside range.
- Fire: if ALIVE, FIRE pressed and cooldown==0, then fire=1 for one frame and cooldown<=FIRE_COOLDOWN-1. Cooldown decrements each frame while >0. Holding FIRE auto-repeats every FIRE_COOLDOWN frames.
- States:
  - ALIVE --hit--> DEAD: counter<=RESPAWN_DELAY-1, alive=0, step=0, keys and fire ignored, position held.
  - DEAD: counter decrements. At 0 -> ALIVE with position=center, angle=0, cooldown=0. hit in DEAD is ignored.
  - Any state, game_end!=0 -> FROZEN: tank_x={spawn_pos[4:0],5'b0}, tank_y={spawn_pos[9:5],5'b0} (zero-extended), angle=0, step=0, fire=0, cooldown=0. Reloaded every frame while game_end!=0.
  - FROZEN, game_end==0 -> ALIVE at the held spawn position. hit is ignored while FROZEN.
- Reset low mid-DEAD or mid-cooldown clears all counters immediately.

Optional Feature:
FIRE_EDGE_EN:
- Defined: fire additionally requires FIRE to have been released since the previous shot (registered fire_seen flag, cleared on release). Holding FIRE yields exactly one pulse.
- Undefined: auto-repeat as above.

Test Plan:
- Reset low 1 frame then high, no keys -> tank_x=300, tank_y=250, angle=0, state=0, fire=0.
- sin=8'h00, cos=8'h7F, keycode slot2=8'h52 for 1 frame -> tank_x=311, tank_y=250, step_x=11. Next frame with wall_hit=4'b0010 -> tank_x=300.
- angle=0, CCW (8'h4F) held 1 frame -> angle=44. Then CW held 2 frames -> angle=1.
- FIRE held 40 frames after reset -> fire pulses on frames 1, 17, 33 (three pulses). With FIRE_EDGE_EN -> one pulse only.
- hit in ALIVE -> state=1, alive=0 for 60 frames, UP ignored, fire=0. Then state=0 at (300,250), angle=0. hit during DEAD does not extend the delay.
- game_end=2'b01, spawn_pos=10'b00011_00101 -> tank_x=160, tank_y=96, state=2, keys ignored. game_end=0 -> state=0 at (160,96).
